// File: rtl/shift_frame_receiver.sv
// Serial frame receiver: start(1), DATA_W data bits LSB first, optional even parity, stop(0).
// Resolves each frame on the stop sample into a single-entry output register with valid/ready.
module shift_frame_receiver #(
   parameter int unsigned DATA_W    = 8,
   parameter bit          PARITY_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              serial_in,
   input  logic              shift_en,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy,
   output logic [7:0]        err_count
);

   localparam int unsigned    CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

   state_e            state_q;
   logic [CntW-1:0]   bit_cnt_q;
   logic [DATA_W-1:0] shreg_q;
   logic              par_mis_q;

   logic resolve, stop_bad, par_bad, good, load, drop_full, err_inc;

   always_comb begin
      resolve   = shift_en && (state_q == StStop);
      stop_bad  = resolve && serial_in;
      par_bad   = resolve && !serial_in && par_mis_q;
      good      = resolve && !serial_in && !par_mis_q;
      // A handshake in the resolve cycle frees the register for the new frame.
      load      = good && (!data_valid || data_ready);
      drop_full = good && data_valid && !data_ready;
      err_inc   = stop_bad || par_bad || drop_full;
   end

   assign busy = (state_q != StIdle);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         par_mis_q  <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         err_count  <= '0;
      end else begin
         frame_err  <= stop_bad;
         parity_err <= par_bad;
         overrun    <= drop_full;

         if (err_inc && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end

         if (load) begin
            data_out   <= shreg_q;
            data_valid <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end

         if (shift_en) begin
            unique case (state_q)
               StIdle: begin
                  if (serial_in) begin
                     state_q   <= StData;
                     bit_cnt_q <= '0;
                     par_mis_q <= 1'b0;
                  end
               end
               StData: begin
                  shreg_q[bit_cnt_q] <= serial_in;
                  bit_cnt_q          <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == LastBit) begin
                     bit_cnt_q <= '0;
                     state_q   <= PARITY_EN ? StParity : StStop;
                  end
               end
               StParity: begin
                  par_mis_q <= serial_in ^ (^shreg_q);
                  state_q   <= StStop;
               end
               StStop: begin
                  state_q <= StIdle;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shift_frame_receiver.sv
// Bench for shift_frame_receiver: table-driven single frames, hand-written corner sequences,
// and randomized frames checked every cycle against a frame-level reference model.
module tb_shift_frame_receiver;

   logic       clk = 1'b0;
   logic       reset, serial_in, shift_en, data_ready;
   logic [7:0] data_out, err_count;
   logic       data_valid, parity_err, frame_err, overrun, busy;

   shift_frame_receiver #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .serial_in  (serial_in),
      .shift_en   (shift_en),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: output register, expected pulses, frame-in-progress, error total.
   bit         m_valid;
   logic [7:0] m_data;
   bit         m_pe, m_fe, m_ov, m_busy;
   int         m_errs;

   int rdy_mode;    // 0: never, 1: always, 2: random, 3: only on the stop sample
   int stall_pct;   // chance of a stall cycle before each bit
   int stall_fixed; // stall cycles forced before each bit

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit get_rdy(input int kind, input bit sen);
      case (rdy_mode)
         0: return 1'b0;
         1: return 1'b1;
         2: return 1'($urandom_range(0, 1));
         default: return (kind == 4) && sen;
      endcase
   endfunction

   task automatic check_model();
      chk("outputs",
          {11'b0, data_valid, data_out, parity_err, frame_err, overrun, busy, err_count},
          {11'b0, m_valid, m_data, m_pe, m_fe, m_ov, m_busy, m_errs[7:0]});
   endtask

   // kind: 0 idle, 1 start, 2 data, 3 parity, 4 stop. fdata/fpar describe the frame on the wire.
   task automatic step(input bit sin, input bit sen, input bit rdy, input int kind,
                       input logic [7:0] fdata, input bit fpar);
      bit good;
      reset      = 1'b0;
      serial_in  = sin;
      shift_en   = sen;
      data_ready = rdy;
      m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      good = 1'b0;
      if (sen && kind == 4) begin
         if (sin) m_fe = 1'b1;
         else if (fpar != ^fdata) m_pe = 1'b1;
         else good = 1'b1;
      end
      if (good && (!m_valid || rdy)) begin
         m_valid = 1'b1;
         m_data  = fdata;
      end else begin
         if (good) m_ov = 1'b1;
         if (m_valid && rdy) m_valid = 1'b0;
      end
      if ((m_pe || m_fe || m_ov) && m_errs < 255) m_errs++;
      if (sen) m_busy = (kind >= 1 && kind <= 3);
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic reset_step();
      reset      = 1'b1;
      serial_in  = 1'b1;
      shift_en   = 1'b1;
      data_ready = 1'b1;
      m_valid = 1'b0; m_data = '0; m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      m_busy = 1'b0; m_errs = 0;
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic send_bit(input bit b, input int kind, input logic [7:0] d, input bit p);
      for (int n = 0; n < stall_fixed; n++)
         step(1'($urandom_range(0, 1)), 1'b0, get_rdy(kind, 1'b0), kind, d, p);
      while (int'($urandom_range(0, 99)) < stall_pct)
         step(1'($urandom_range(0, 1)), 1'b0, get_rdy(kind, 1'b0), kind, d, p);
      step(b, 1'b1, get_rdy(kind, 1'b1), kind, d, p);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      bit p;
      p = (^d) ^ bad_par;
      send_bit(1'b1, 1, d, p);
      for (int i = 0; i < 8; i++) send_bit(d[i], 2, d, p);
      send_bit(p, 3, d, p);
      send_bit(bad_stop, 4, d, p);
   endtask

   typedef struct {
      logic [7:0] data;
      bit         bad_par;
      bit         bad_stop;
      int         rdy;
      bit         e_valid;
      logic [7:0] e_data;
      bit         e_pe;
      bit         e_fe;
      logic [7:0] e_errs;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{8'hA5, 1'b0, 1'b0, 0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'd0};
      tbl[1] = '{8'hA5, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd1};
      tbl[2] = '{8'hA5, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd1};
      tbl[3] = '{8'hA5, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd1};
      tbl[4] = '{8'h00, 1'b0, 1'b0, 0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0};
      tbl[5] = '{8'hFF, 1'b0, 1'b0, 0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'd0};
      tbl[6] = '{8'h3C, 1'b0, 1'b0, 1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'd0};
      stall_pct   = 0;
      stall_fixed = 0;

      reset_step();
      for (int i = 0; i < 7; i++) begin
         reset_step();
         rdy_mode = tbl[i].rdy;
         send_frame(tbl[i].data, tbl[i].bad_par, tbl[i].bad_stop);
         chk("tbl_valid", 32'(data_valid), 32'(tbl[i].e_valid));
         chk("tbl_data", 32'(data_out), 32'(tbl[i].e_data));
         chk("tbl_parity_err", 32'(parity_err), 32'(tbl[i].e_pe));
         chk("tbl_frame_err", 32'(frame_err), 32'(tbl[i].e_fe));
         chk("tbl_err_count", 32'(err_count), 32'(tbl[i].e_errs));
      end

      // Overrun, then a handshake landing exactly on the resolve cycle, then a plain drain.
      reset_step();
      rdy_mode = 0;
      send_frame(8'h3C, 1'b0, 1'b0);
      send_frame(8'h81, 1'b0, 1'b0);
      chk("ovr_pulse", 32'(overrun), 32'd1);
      chk("ovr_data_held", 32'(data_out), 32'h3C);
      chk("ovr_valid_held", 32'(data_valid), 32'd1);
      rdy_mode = 3;
      send_frame(8'h81, 1'b0, 1'b0);
      chk("hs_reload_data", 32'(data_out), 32'h81);
      chk("hs_no_overrun", 32'(overrun), 32'd0);
      chk("hs_valid", 32'(data_valid), 32'd1);
      step(1'b0, 1'b1, 1'b1, 0, 8'h00, 1'b0);
      chk("drain_valid", 32'(data_valid), 32'd0);

      // Alternating shift_en, then reset after the 4th data bit, then a clean frame.
      reset_step();
      rdy_mode    = 0;
      stall_fixed = 1;
      send_frame(8'h5A, 1'b0, 1'b0);
      chk("stall_data", 32'(data_out), 32'h5A);
      chk("stall_valid", 32'(data_valid), 32'd1);
      stall_fixed = 0;
      reset_step();
      send_bit(1'b1, 1, 8'hF0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 2, 8'hF0, 1'b0);
      reset_step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pulses", {29'b0, parity_err, frame_err, overrun}, 32'd0);
      send_frame(8'h0F, 1'b0, 1'b0);
      chk("post_rst_data", 32'(data_out), 32'h0F);
      chk("post_rst_errs", 32'(err_count), 32'd0);

      // Error counter saturation.
      reset_step();
      for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1, 1'b0);
      chk("sat_255", 32'(err_count), 32'd255);
      send_frame(8'h11, 1'b1, 1'b0);
      chk("sat_hold", 32'(err_count), 32'd255);

      // Randomized frames, stalls, gaps and consumer behaviour.
      reset_step();
      rdy_mode  = 2;
      stall_pct = 30;
      for (int f = 0; f < 300; f++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) step(1'b0, 1'b1, get_rdy(0, 1'b1), 0, 8'h00, 1'b0);
         send_frame(8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_frame_receiver.md
SHIFT_FRAME_RECEIVER -- requirements
Module: shift_frame_receiver

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving data bits per frame (legal range 4..8).
REQ-002 The block SHALL have parameter PARITY_EN, default 1; when 1, an even-parity bit follows the data bits, and when 0, no parity bit is sent.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port serial_in, input, 1, the serial bit stream from the upstream universal shift register's serial output.
REQ-006 The block SHALL have port shift_en, input, 1, the bit strobe; serial_in is sampled only on cycles where shift_en=1.
REQ-007 The block SHALL have port data_out, output, DATA_W, the received frame payload.
REQ-008 The block SHALL have port data_valid, output, 1, which is high while data_out holds an unconsumed frame.
REQ-009 The block SHALL have port data_ready, input, 1, the consumer accept signal.
REQ-010 The block SHALL have port parity_err, output, 1, a one-cycle pulse on a parity mismatch.
REQ-011 The block SHALL have port frame_err, output, 1, a one-cycle pulse on a bad stop bit.
REQ-012 The block SHALL have port overrun, output, 1, a one-cycle pulse when a good frame is dropped because the output is full.
REQ-013 The block SHALL have port busy, output, 1, which is high whenever the FSM is not in IDLE.
REQ-014 The block SHALL have port err_count, output, 8, a saturating count of all error pulses.

Function
REQ-015 Frame format SHALL be: start bit = 1, DATA_W data bits LSB first, optional parity bit, stop bit = 0; the idle line is 0.
REQ-016 The FSM SHALL have states IDLE, DATA, PARITY, and STOP; transitions occur only on cycles with shift_en=1.
REQ-017 In IDLE, a sampled 1 SHALL move the FSM to DATA with bit_cnt=0; a sampled 0 keeps the FSM in IDLE.
REQ-018 In DATA, each sample SHALL be stored at bit position bit_cnt, then bit_cnt increments; after bit DATA_W-1 the FSM moves to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-019 In PARITY, the sample SHALL be compared against the XOR of the data bits (even parity); the result is held as a mismatch flag and the FSM moves to STOP.
REQ-020 In STOP, the FSM SHALL return to IDLE after the sample, and the frame is resolved in that same cycle with registered outputs visible the next cycle.
REQ-021 Resolution priority SHALL be: stop sample = 1 gives a frame_err pulse and the frame is dropped; otherwise a parity mismatch gives a parity_err pulse and the frame is dropped; otherwise the frame is good.
REQ-022 Good frame with the output empty, or with data_valid and data_ready both high in the resolve cycle: data_out SHALL load and data_valid SHALL be 1 the next cycle (latency 1 cycle after the stop-bit sample).
REQ-023 Good frame while data_valid=1 and data_ready=0: overrun SHALL pulse, the new frame is discarded, and data_out and data_valid are unchanged.
REQ-024 data_valid SHALL clear the cycle after data_valid and data_ready are both high, unless it is reloaded per REQ-022.
REQ-025 data_out SHALL be stable while data_valid=1 and no handshake occurs.
REQ-026 Each error pulse SHALL increment err_count by 1; err_count saturates at 255 and never wraps.
REQ-027 Cycles with shift_en=0 SHALL leave the FSM, bit_cnt, and the partial data unchanged, for any stall length.
REQ-028 data_ready while data_valid=0 SHALL be ignored.

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL set: FSM to IDLE, bit_cnt=0, partial data=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, err_count=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no error pulse, and the next frame is received normally.
REQ-031 Reset SHALL take priority over shift_en and data_ready in the same cycle.

Verification
REQ-032 Scenario: with shift_en=1 every cycle, send 0xA5 as bits 1,1,0,1,0,0,1,0,1,0,0, with data_ready=0 -> data_valid=1 and data_out=0xA5 one cycle after the stop sample, and no error pulses.
REQ-033 Scenario: send the 0xA5 frame with parity bit 1 -> one parity_err pulse, data_valid stays 0, and err_count=1.
REQ-034 Scenario: send the 0xA5 frame with stop bit 1 -> one frame_err pulse and data_valid stays 0, even though the parity is also checked.
REQ-035 Scenario: frame 0x3C held with data_ready=0, then frame 0x81 completes -> overrun pulse and data_out stays 0x3C; repeating with data_ready=1 in the resolve cycle -> data_out=0x81 and no overrun.
REQ-036 Scenario: shift_en toggling 1/0 while sending 0x5A -> data_out=0x5A, the same as the unstalled case; reset asserted after the 4th data bit -> busy=0 next cycle, no pulses, and a subsequent frame of 0x0F is received correctly.
REQ-037 Scenario: 256 consecutive parity-error frames -> err_count=255, holding at 255.
